dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MEM pipeline stage and the shared SRAM memory controller. It serves word loads from a register-based line array and refills 4-word (128-bit) lines on miss. Every store is forwarded to memory as a single-word write, and the cached copy is updated on a hit. It drives the controller's DCache request port (`memory_valid_for_DCache` / `memory_for_store` / `load_store_data_addr` / `data_to_store`) and consumes its `memory_ready_for_DCache` / `data_from_mem` response.

---
 rtl/dcache_ctrl_if.sv | 25 ++
 rtl/dcache_ctrl.sv | 131 +++++++++++++
 tb/tb_dcache_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - pipeline and memory-controller signals of the data cache
interface dcache_ctrl_if;
    logic         req_valid;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic         mem_valid;
    logic         mem_store;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ready;
    logic [127:0] mem_line;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_line,
        output rdata, stall, mem_valid, mem_store, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_line,
        input  rdata, stall, mem_valid, mem_store, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache
module dcache_ctrl #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 32 - 4 - INDEX_BITS
) (
    input  logic         clk,
    input  logic         rst,
    dcache_ctrl_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_t;

    state_t r_state;
    state_t w_next;

    logic                r_valid [LINES];
    logic [TAG_BITS-1:0] r_tag   [LINES];
    logic [31:0]         r_data  [LINES][4];

    logic                  r_mem_valid;
    logic                  r_mem_store;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic [1:0]            w_word;
    logic                  w_hit;
    logic                  w_fill;
    logic                  w_wr_hit;
    logic                  w_issue_rd;
    logic                  w_issue_wr;
    logic                  w_stall;

    assign w_index = bus.req_addr[3+INDEX_BITS:4];
    assign w_tag   = bus.req_addr[31:4+INDEX_BITS];
    assign w_word  = bus.req_addr[3:2];
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

    assign w_issue_rd = (r_state == S_IDLE) && bus.req_valid && !bus.req_we && !w_hit;
    assign w_issue_wr = (r_state == S_IDLE) && bus.req_valid && bus.req_we;
    assign w_fill     = (r_state == S_REFILL) && bus.mem_ready;
    assign w_wr_hit   = (r_state == S_WRITE) && bus.mem_ready && w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue_wr) begin
                    w_next = S_WRITE;
                end else if (w_issue_rd) begin
                    w_next = S_REFILL;
                end
            end
            S_REFILL: if (bus.mem_ready) w_next = S_IDLE;
            S_WRITE:  if (bus.mem_ready) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:   w_stall = w_issue_rd || w_issue_wr;
            S_REFILL: w_stall = 1'b1;
            S_WRITE:  w_stall = 1'b1;
            S_DONE:   w_stall = 1'b0;
            default:  w_stall = 1'b0;
        endcase
    end

    // mem_valid must drop on the edge that samples mem_ready, or the controller restarts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_mem_store <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
        end else if (w_issue_wr) begin
            r_mem_valid <= 1'b1;
            r_mem_store <= 1'b1;
            r_mem_addr  <= bus.req_addr;
            r_mem_wdata <= bus.req_wdata;
        end else if (w_issue_rd) begin
            r_mem_valid <= 1'b1;
            r_mem_store <= 1'b0;
            r_mem_addr  <= {bus.req_addr[31:4], 4'h0};
        end else if ((r_state == S_REFILL || r_state == S_WRITE) && bus.mem_ready) begin
            r_mem_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_fill) begin
            r_valid[w_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_index] <= w_tag;
            for (int i = 0; i < 4; i++) begin
                r_data[w_index][i] <= bus.mem_line[32*i +: 32];
            end
        end else if (w_wr_hit) begin
            r_data[w_index][w_word] <= bus.req_wdata;
        end
    end

    assign bus.rdata     = r_data[w_index][w_word];
    assign bus.stall     = w_stall;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_store = r_mem_store;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.INDEX_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: backing memory plus which line address each index holds
    logic [31:0] bmem [logic [31:0]];
    bit          res_v    [64];
    logic [27:0] res_line [64];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [127:0] rd_line(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        return {rd_mem(base + 32'd12), rd_mem(base + 32'd8), rd_mem(base + 32'd4), rd_mem(base)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) res_v[i] = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check("idle_stall", {31'd0, bus.stall}, 32'd0);
        check("idle_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int lat);
        int          idx;
        bit          hitm;
        logic [31:0] exp_addr;
        idx  = int'(addr[9:4]);
        hitm = res_v[idx] && (res_line[idx] == addr[31:4]);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        #1;
        if (!we && hitm) begin
            check("hit_stall", {31'd0, bus.stall}, 32'd0);
            check("hit_rdata", bus.rdata, rd_mem(addr));
            check("hit_no_mem", {31'd0, bus.mem_valid}, 32'd0);
        end else begin
            exp_addr = we ? addr : {addr[31:4], 4'h0};
            check("req_stall", {31'd0, bus.stall}, 32'd1);
            @(negedge clk);
            check("mem_valid", {31'd0, bus.mem_valid}, 32'd1);
            check("mem_store", {31'd0, bus.mem_store}, {31'd0, we});
            check("mem_addr", bus.mem_addr, exp_addr);
            if (we) check("mem_wdata", bus.mem_wdata, wd);
            for (int c = 1; c < lat; c++) begin
                @(negedge clk);
                check("wait_stall", {31'd0, bus.stall}, 32'd1);
                check("wait_valid", {31'd0, bus.mem_valid}, 32'd1);
                check("wait_addr", bus.mem_addr, exp_addr);
            end
            bus.mem_ready = 1'b1;
            bus.mem_line  = rd_line(addr);
            if (we) bmem[addr] = wd;
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.mem_line  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("post_valid", {31'd0, bus.mem_valid}, 32'd0);
            check("post_stall", {31'd0, bus.stall}, 32'd0);
            if (!we) begin
                res_v[idx]    = 1'b1;
                res_line[idx] = addr[31:4];
                check("fill_rdata", bus.rdata, rd_mem(addr));
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.mem_ready = 1'b0;
        bus.mem_line  = 128'h0;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("rst_mem_store", {31'd0, bus.mem_store}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);

        // cold load, then word 3 of the same line
        do_req(1'b0, 32'h8040_0010, 32'h0, 3);
        do_req(1'b0, 32'h8040_001C, 32'h0, 1);
        // store hit, then read back without memory traffic
        do_req(1'b1, 32'h8040_0014, 32'hDEAD_BEEF, 2);
        do_req(1'b0, 32'h8040_0014, 32'h0, 1);
        check("store_hit_rdata", bus.rdata, 32'hDEAD_BEEF);
        // conflict miss on the same index
        do_req(1'b0, 32'h8040_0410, 32'h0, 2);
        do_req(1'b0, 32'h8040_0010, 32'h0, 2);
        // store miss does not allocate
        do_req(1'b1, 32'h8050_0000, 32'h1234_5678, 1);
        do_req(1'b0, 32'h8050_0000, 32'h0, 2);
        check("store_miss_rdata", bus.rdata, 32'h1234_5678);
        // long handshake
        do_req(1'b0, 32'h8060_0020, 32'h0, 20);
        idle_cycle();
        idle_cycle();

        // reset in the middle of a refill
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h8070_0030;
        repeat (3) @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("abort_stall", {31'd0, bus.stall}, 32'd0);
        clear_model();
        do_req(1'b0, 32'h8040_0010, 32'h0, 2);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = 32'h8040_0000 + ($urandom_range(0, 2) * 32'h400)
                + ($urandom_range(0, 3) * 32'h10) + ($urandom_range(0, 3) * 32'h4);
            if ($urandom_range(0, 9) == 0) idle_cycle();
            do_req($urandom_range(0, 9) < 3, a, $urandom, int'($urandom_range(1, 5)));
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
